// File: rtl/icache_assoc.sv
// ---------------------------------------------------------------------------
// icache_assoc
//   N-way set-associative instruction cache for the Otter fetch stage.
//   Hits are answered combinationally; a miss stalls fetch while one block is
//   burst-read from memory into a line buffer, then written into the victim
//   way (lowest invalid way, otherwise the true-LRU way).  A flush pulse
//   invalidates every line; a flush arriving mid-refill is held until the
//   refill commits so the new line is invalidated as well.
//
// Ports
//   CLK, RST_N         clock, asynchronous active-low reset
//   cpu_req/cpu_addr   fetch request and byte address (bits [1:0] ignored)
//   cpu_rdata          instruction word, nop (0x13) when not hitting
//   cpu_hit/cpu_stall  lookup result and fetch stall
//   flush              invalidate-all pulse
//   mem_req/mem_addr   block read request (held until mem_gnt), aligned addr
//   mem_gnt            request accepted
//   mem_rvalid/rdata   one beat of block data, word 0 first
// ---------------------------------------------------------------------------
module icache_assoc #(
  parameter int NUM_WAYS    = 4,
  parameter int NUM_SETS    = 16,
  parameter int BLOCK_WORDS = 4,
  parameter int ADDR_W      = 32
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_hit,
  output logic              cpu_stall,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  localparam int WAY_W = $clog2(NUM_WAYS);
  localparam int WRD_W = $clog2(BLOCK_WORDS);
  localparam int IDX   = $clog2(NUM_SETS);
  localparam int OFF   = 2 + WRD_W;
  localparam int TAG   = ADDR_W - IDX - OFF;
  localparam int BLK_W = ADDR_W - OFF;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REQ    = 2'd1;
  localparam logic [1:0] FILL   = 2'd2;
  localparam logic [1:0] COMMIT = 2'd3;

  // Control state (reset)
  logic [1:0]                       state_q, state_d;
  logic [BLK_W-1:0]                 blk_q, blk_d;
  logic [WAY_W-1:0]                 victim_q, victim_d;
  logic [WRD_W-1:0]                 beat_q, beat_d;
  logic                             flush_pend_q, flush_pend_d;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0] valid_q, valid_d;
  logic [WAY_W-1:0]                 age_q [NUM_SETS][NUM_WAYS];
  logic [WAY_W-1:0]                 age_d [NUM_SETS][NUM_WAYS];

  // Storage (not reset)
  logic [31:0]    data_q [NUM_WAYS][NUM_SETS][BLOCK_WORDS];
  logic [TAG-1:0] tag_q  [NUM_WAYS][NUM_SETS];
  logic [31:0]    buf_q  [BLOCK_WORDS];

  // Request address fields
  logic [WRD_W-1:0] req_word;
  logic [IDX-1:0]   req_idx;
  logic [TAG-1:0]   req_tag;
  logic [BLK_W-1:0] req_blk;
  logic [IDX-1:0]   blk_idx;
  logic [TAG-1:0]   blk_tag;
  logic             unused_addr_bits;

  assign req_word = cpu_addr[OFF-1:2];
  assign req_idx  = cpu_addr[OFF+IDX-1:OFF];
  assign req_tag  = cpu_addr[ADDR_W-1:OFF+IDX];
  assign req_blk  = cpu_addr[ADDR_W-1:OFF];
  assign blk_idx  = blk_q[IDX-1:0];
  assign blk_tag  = blk_q[BLK_W-1:IDX];
  assign unused_addr_bits = ^cpu_addr[1:0];

  // Tag compare across every way of the addressed set.  Scanning from the
  // top down lets the lowest matching way win if more than one matches.
  logic             hit_any;
  logic [WAY_W-1:0] hit_way;

  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (valid_q[req_idx][w] && (tag_q[w][req_idx] == req_tag)) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Victim choice: the lowest invalid way if there is one, otherwise the
  // way whose age says it is least recently used.
  logic             inv_found;
  logic [WAY_W-1:0] victim_way;

  always_comb begin
    inv_found  = 1'b0;
    victim_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_q[req_idx][w]) begin
        inv_found  = 1'b1;
        victim_way = WAY_W'(w);
      end
    end
    if (!inv_found) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (age_q[req_idx][w] == WAY_W'(NUM_WAYS - 1)) begin
          victim_way = WAY_W'(w);
        end
      end
    end
  end

  // CPU-facing outputs; hits are only reported while idle.
  logic in_idle;

  assign in_idle   = (state_q == IDLE);
  assign cpu_hit   = cpu_req & hit_any & in_idle;
  assign cpu_rdata = cpu_hit ? data_q[hit_way][req_idx][req_word] : 32'h0000_0013;
  assign cpu_stall = (cpu_req & ~cpu_hit) | ~in_idle;
  assign mem_req   = (state_q == REQ);
  assign mem_addr  = (state_q == REQ) ? {blk_q, {OFF{1'b0}}} : '0;

  // LRU touch: a hit in IDLE or the commit of a refilled victim.  The
  // touched way goes to age 0 and every younger way ages by one, which
  // keeps each set's ages a permutation.
  logic             lru_en;
  logic [IDX-1:0]   lru_set;
  logic [WAY_W-1:0] lru_way;
  logic [WAY_W-1:0] old_age;

  always_comb begin
    lru_en  = 1'b0;
    lru_set = req_idx;
    lru_way = hit_way;
    if (cpu_hit) begin
      lru_en = 1'b1;
    end else if (state_q == COMMIT) begin
      lru_en  = 1'b1;
      lru_set = blk_idx;
      lru_way = victim_q;
    end
    old_age = age_q[lru_set][lru_way];
    age_d   = age_q;
    if (lru_en) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (WAY_W'(w) == lru_way) begin
          age_d[lru_set][w] = '0;
        end else if (age_q[lru_set][w] < old_age) begin
          age_d[lru_set][w] = age_q[lru_set][w] + WAY_W'(1);
        end
      end
    end
  end

  // Refill state machine.  A flush in IDLE wins over a same-cycle miss; a
  // flush seen later is remembered and applied on the commit edge so the
  // freshly written line ends up invalid too.
  always_comb begin
    state_d      = state_q;
    blk_d        = blk_q;
    victim_d     = victim_q;
    beat_d       = beat_q;
    flush_pend_d = flush_pend_q;
    valid_d      = valid_q;
    case (state_q)
      IDLE: begin
        if (flush) begin
          valid_d = '0;
        end else if (cpu_req && !hit_any) begin
          blk_d    = req_blk;
          victim_d = victim_way;
          state_d  = REQ;
        end
      end
      REQ: begin
        flush_pend_d = flush_pend_q | flush;
        if (mem_gnt) begin
          beat_d  = '0;
          state_d = FILL;
        end
      end
      FILL: begin
        flush_pend_d = flush_pend_q | flush;
        if (mem_rvalid) begin
          beat_d = beat_q + WRD_W'(1);
          if (beat_q == WRD_W'(BLOCK_WORDS - 1)) begin
            state_d = COMMIT;
          end
        end
      end
      default: begin
        valid_d[blk_idx][victim_q] = 1'b1;
        if (flush_pend_q || flush) begin
          valid_d = '0;
        end
        flush_pend_d = 1'b0;
        state_d      = IDLE;
      end
    endcase
  end

  // Control registers; reset abandons any refill in flight and restores
  // the ages to way i = i.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      blk_q        <= '0;
      victim_q     <= '0;
      beat_q       <= '0;
      flush_pend_q <= 1'b0;
      valid_q      <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          age_q[s][w] <= WAY_W'(w);
        end
      end
    end else begin
      state_q      <= state_d;
      blk_q        <= blk_d;
      victim_q     <= victim_d;
      beat_q       <= beat_d;
      flush_pend_q <= flush_pend_d;
      valid_q      <= valid_d;
      age_q        <= age_d;
    end
  end

  // Line buffer collects beats during FILL; the data and tag arrays are
  // written from it on the COMMIT edge.  None of this needs a reset because
  // the valid bits guard every read.
  always_ff @(posedge CLK) begin
    if ((state_q == FILL) && mem_rvalid) begin
      buf_q[beat_q] <= mem_rdata;
    end
    if (state_q == COMMIT) begin
      for (int b = 0; b < BLOCK_WORDS; b++) begin
        data_q[victim_q][blk_idx][b] <= buf_q[b];
      end
      tag_q[victim_q][blk_idx] <= blk_tag;
    end
  end

endmodule

// File: tb/tb_icache_assoc.sv
// ---------------------------------------------------------------------------
// tb_icache_assoc
//   Directed and randomised bench for icache_assoc with default parameters.
//   A reference model keeps, per set, the list of resident block addresses
//   ordered most-recently-used first; memory contents come from a fixed
//   function of the word address.
// ---------------------------------------------------------------------------
module tb_icache_assoc;

  localparam int NW   = 4;
  localparam int NS   = 16;
  localparam int BW   = 4;
  localparam int AW   = 32;
  localparam int OFFB = 2 + $clog2(BW);

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          cpu_req = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [31:0]   cpu_rdata;
  logic          cpu_hit;
  logic          cpu_stall;
  logic          flush = 1'b0;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_gnt = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [31:0]   mem_rdata = '0;

  int assertCount = 0;
  int failCount = 0;

  int unsigned setQ [NS][$];
  int unsigned saved [$];

  icache_assoc #(
    .NUM_WAYS(NW), .NUM_SETS(NS), .BLOCK_WORDS(BW), .ADDR_W(AW)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_rdata(cpu_rdata),
    .cpu_hit(cpu_hit), .cpu_stall(cpu_stall), .flush(flush),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 CLK = ~CLK;

  // Backing memory: block 0x100 holds 0xA0..0xA3, everything else a hash.
  function automatic logic [31:0] memWord(input logic [31:0] addr);
    logic [31:0] a;
    a = addr & ~32'h3;
    if (a[31:4] == 28'h10) return 32'hA0 + {28'h0, a[3:2]};
    return (a * 32'h9E37_79B1) ^ 32'h0000_1234;
  endfunction

  function automatic bit modelHit(input logic [31:0] addr);
    int unsigned blk;
    int s;
    blk = addr >> OFFB;
    s = int'(blk % NS);
    foreach (setQ[s][i]) if (setQ[s][i] == blk) return 1'b1;
    return 1'b0;
  endfunction

  task automatic modelTouch(input logic [31:0] addr);
    int unsigned blk;
    int s;
    int pos;
    blk = addr >> OFFB;
    s = int'(blk % NS);
    pos = -1;
    foreach (setQ[s][i]) if (setQ[s][i] == blk) pos = i;
    if (pos >= 0) setQ[s].delete(pos);
    setQ[s].push_front(blk);
  endtask

  task automatic modelInsert(input logic [31:0] addr);
    int unsigned blk;
    int s;
    blk = addr >> OFFB;
    s = int'(blk % NS);
    if (setQ[s].size() == NW) void'(setQ[s].pop_back());
    setQ[s].push_front(blk);
  endtask

  task automatic modelFlush();
    for (int s = 0; s < NS; s++) setQ[s].delete();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full miss sequence: miss cycle, REQ (grant after gd extra cycles),
  // BW beats each preceded by gap idle cycles, COMMIT, then the hit.
  task automatic doMiss(input logic [31:0] addr, input int gd, input int gap, input bit flushMid);
    logic [31:0] blk;
    blk = addr & ~32'(BW * 4 - 1);
    @(negedge CLK);
    cpu_req = 1'b1;
    cpu_addr = addr;
    #1;
    checkOutput("miss_hit", cpu_hit, 0);
    checkOutput("miss_stall", cpu_stall, 1);
    checkOutput("miss_rdata", cpu_rdata, 32'h13);
    for (int i = 0; i <= gd; i++) begin
      @(negedge CLK);
      mem_gnt = (i == gd);
      #1;
      checkOutput("req_valid", mem_req, 1);
      checkOutput("req_addr", mem_addr, blk);
    end
    for (int b = 0; b < BW; b++) begin
      for (int g = 0; g < gap; g++) begin
        @(negedge CLK);
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        flush = 1'b0;
        #1;
        checkOutput("fill_req_low", mem_req, 0);
        checkOutput("fill_stall", cpu_stall, 1);
      end
      @(negedge CLK);
      mem_gnt = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata = memWord(blk + 32'(4 * b));
      flush = flushMid && (b == 1);
      #1;
      checkOutput("fill_req_low", mem_req, 0);
      checkOutput("fill_hit", cpu_hit, 0);
    end
    @(negedge CLK);
    mem_rvalid = 1'b0;
    flush = 1'b0;
    #1;
    checkOutput("commit_stall", cpu_stall, 1);
    checkOutput("commit_hit", cpu_hit, 0);
    modelInsert(addr);
    if (flushMid) begin
      modelFlush();
    end else begin
      @(negedge CLK);
      #1;
      checkOutput("refill_hit", cpu_hit, 1);
      checkOutput("refill_rdata", cpu_rdata, memWord(addr));
      checkOutput("refill_stall", cpu_stall, 0);
    end
  endtask

  // One fetch: a model hit must hit at zero latency, otherwise a refill.
  task automatic applyStimulus(input logic [31:0] addr, input int gd, input int gap);
    if (modelHit(addr)) begin
      @(negedge CLK);
      cpu_req = 1'b1;
      cpu_addr = addr;
      #1;
      checkOutput("hit", cpu_hit, 1);
      checkOutput("hit_rdata", cpu_rdata, memWord(addr));
      checkOutput("hit_stall", cpu_stall, 0);
      modelTouch(addr);
    end else begin
      doMiss(addr, gd, gap, 1'b0);
    end
  endtask

  task automatic flushIdle();
    @(negedge CLK);
    cpu_req = 1'b0;
    flush = 1'b1;
    #1;
    checkOutput("flush_req", mem_req, 0);
    @(negedge CLK);
    flush = 1'b0;
    modelFlush();
  endtask

  // Directed sequence followed by a randomised phase.
  initial begin
    // Reset state with a request pending
    cpu_req = 1'b1;
    cpu_addr = 32'h100;
    #2;
    checkOutput("rst_hit", cpu_hit, 0);
    checkOutput("rst_stall", cpu_stall, 1);
    checkOutput("rst_rdata", cpu_rdata, 32'h13);
    checkOutput("rst_mem_req", mem_req, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    cpu_req = 1'b0;
    #1;
    checkOutput("idle_stall", cpu_stall, 0);

    // Cold miss with minimum timing, then a zero-latency hit in the block
    doMiss(32'h104, 0, 0, 1'b0);
    applyStimulus(32'h10C, 0, 0);

    // Five tags in set 0; 0x100 is LRU after 0x000 is re-touched
    applyStimulus(32'h000, 0, 0);
    applyStimulus(32'h200, 0, 0);
    applyStimulus(32'h300, 0, 0);
    applyStimulus(32'h000, 0, 0);
    applyStimulus(32'h400, 0, 0);
    applyStimulus(32'h000, 0, 0);
    applyStimulus(32'h100, 0, 0);

    // Delayed grant and gaps between beats
    doMiss(32'h500, 3, 2, 1'b0);

    // Flush in IDLE together with a miss: flush wins, no refill starts
    saved.delete();
    for (int s = 0; s < NS; s++) foreach (setQ[s][i]) saved.push_back(setQ[s][i]);
    @(negedge CLK);
    cpu_req = 1'b1;
    cpu_addr = 32'h700;
    flush = 1'b1;
    #1;
    checkOutput("flush_miss_stall", cpu_stall, 1);
    @(negedge CLK);
    flush = 1'b0;
    cpu_req = 1'b0;
    #1;
    checkOutput("flush_no_req", mem_req, 0);
    modelFlush();
    foreach (saved[k]) applyStimulus(saved[k] << OFFB, 0, 0);

    // Flush during FILL: commit completes, the line is then invalid
    doMiss(32'h810, 1, 1, 1'b1);
    doMiss(32'h810, 0, 0, 1'b0);

    // Reset in the middle of FILL with stray beats afterwards
    @(negedge CLK);
    cpu_req = 1'b1;
    cpu_addr = 32'h620;
    #1;
    checkOutput("rf_miss_stall", cpu_stall, 1);
    @(negedge CLK);
    mem_gnt = 1'b1;
    #1;
    checkOutput("rf_req", mem_req, 1);
    for (int b = 0; b < 2; b++) begin
      @(negedge CLK);
      mem_gnt = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata = 32'hDEAD_0000 + 32'(b);
    end
    @(negedge CLK);
    RST_N = 1'b0;
    cpu_req = 1'b0;
    mem_rdata = 32'hDEAD_0002;
    #1;
    checkOutput("rf_req_low", mem_req, 0);
    checkOutput("rf_addr_zero", mem_addr, 0);
    checkOutput("rf_stall", cpu_stall, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    mem_rdata = 32'hDEAD_0003;
    #1;
    checkOutput("rf_stray_req", mem_req, 0);
    @(negedge CLK);
    mem_rvalid = 1'b0;
    modelFlush();
    applyStimulus(32'h810, 0, 0);
    doMiss(32'h620, 0, 0, 1'b0);

    // Random fetches over a handful of conflicting tags
    for (int n = 0; n < 80; n++) begin
      logic [31:0] a;
      a = (32'($urandom_range(0, 5)) << 8) | (32'($urandom_range(0, 2)) << 4)
          | (32'($urandom_range(0, 3)) << 2);
      if ($urandom_range(0, 15) == 0) flushIdle();
      applyStimulus(a, int'($urandom_range(0, 2)), int'($urandom_range(0, 1)));
    end

    @(negedge CLK);
    cpu_req = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
